// File: rtl/fifo_sdp_ram2.sv
// fifo_sdp_ram2: simple-dual-port RAM with a registered read address and a
// resettable, read-enabled output register (two-cycle read).
module fifo_sdp_ram2 #(
    parameter string MEM_STYLE  = "auto",
    parameter int    DATA_WIDTH = 64,
    parameter int    DEPTH      = 32,
    parameter int    ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  rden,
    output logic [DATA_WIDTH-1:0] dout
);
    (* ram_style = MEM_STYLE *) logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] raddr_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= din;
        raddr_q <= raddr;
    end

    always_ff @(posedge clk)
        if (reset) dout <= '0;
        else if (rden) dout <= mem[raddr_q];
endmodule

// File: rtl/fifo_fwft_sdp.sv
// fifo_fwft_sdp: first-word-fall-through FIFO over a two-cycle SDP RAM, with a
// 4-entry register prefetch stage fed on credits so reads sustain 1 word/cycle.
module fifo_fwft_sdp #(
    parameter string MEM_STYLE    = "auto",
    parameter int    DATA_WIDTH   = 64,
    parameter int    DEPTH        = 32,
    parameter int    ADDR_WIDTH   = 6,
    parameter int    AFULL_LEVEL  = DEPTH - 2,
    parameter int    AEMPTY_LEVEL = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   if_num_data,
    output logic                  if_almost_full,
    output logic                  if_almost_empty
);
    localparam int STAGE_DEPTH = 4;
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int SW = $clog2(STAGE_DEPTH);

    logic [CNT_W-1:0]      cnt, ram_cnt;
    logic [ADDR_WIDTH-1:0] wptr, rptr;
    logic                  wr, rd, iss, iss_q, land_q;
    logic [DATA_WIDTH-1:0] ram_dout;
    logic [DATA_WIDTH-1:0] stg [STAGE_DEPTH];
    logic [SW-1:0]         sh, st;
    logic [SW:0]           sc;

    function automatic logic [ADDR_WIDTH-1:0] nxt(input logic [ADDR_WIDTH-1:0] p);
        return p == ADDR_WIDTH'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign if_full_n       = !reset && cnt != CNT_W'(DEPTH);
    assign if_empty_n      = !reset && sc != '0;
    assign if_dout         = reset ? '0 : stg[sh];
    assign if_num_data     = reset ? '0 : cnt;
    assign if_almost_full  = !reset && cnt >= CNT_W'(AFULL_LEVEL);
    assign if_almost_empty = reset || cnt <= CNT_W'(AEMPTY_LEVEL);
    assign wr = if_write && if_full_n;
    assign rd = if_read && if_empty_n;
    // Reserve a staging slot for every read still inside the RAM pipeline.
    assign iss = ram_cnt != '0 &&
                 (sc + (SW+1)'(iss_q) + (SW+1)'(land_q)) < (SW+1)'(STAGE_DEPTH);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            ram_cnt <= '0;
            wptr    <= '0;
            rptr    <= '0;
            iss_q   <= 1'b0;
            land_q  <= 1'b0;
            sh      <= '0;
            st      <= '0;
            sc      <= '0;
        end else begin
            cnt     <= cnt + CNT_W'(wr) - CNT_W'(rd);
            ram_cnt <= ram_cnt + CNT_W'(wr) - CNT_W'(iss);
            if (wr) wptr <= nxt(wptr);
            if (iss) rptr <= nxt(rptr);
            iss_q  <= iss;
            land_q <= iss_q;
            if (land_q) st <= st + 1'b1;
            if (rd) sh <= sh + 1'b1;
            sc <= sc + (SW+1)'(land_q) - (SW+1)'(rd);
        end
    end

    always_ff @(posedge clk)
        if (reset) stg <= '{default: '0};
        else if (land_q) stg[st] <= ram_dout;

    fifo_sdp_ram2 #(
        .MEM_STYLE (MEM_STYLE),
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .reset(reset),
        .we   (wr),
        .waddr(wptr),
        .din  (if_din),
        .raddr(rptr),
        .rden (iss_q),
        .dout (ram_dout)
    );
endmodule

// File: tb/tb_fifo_fwft_sdp.sv
// tb_fifo_fwft_sdp: directed vectors and sequences on a DEPTH=32 FIFO, then
// randomized traffic on a DEPTH=20 FIFO against a queue model.
module tb_fifo_fwft_sdp;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        w32 = 1'b0, r32 = 1'b0, fn32, en32, af32, ae32;
    logic [63:0] d32 = '0, dout32;
    logic [6:0]  num32;
    logic        w20 = 1'b0, r20 = 1'b0, fn20, en20, af20, ae20;
    logic [63:0] d20 = '0, dout20;
    logic [5:0]  num20;

    fifo_fwft_sdp #(.DEPTH(32), .ADDR_WIDTH(6)) u32 (
        .clk(clk), .reset(reset), .if_write(w32), .if_din(d32), .if_full_n(fn32),
        .if_read(r32), .if_dout(dout32), .if_empty_n(en32), .if_num_data(num32),
        .if_almost_full(af32), .if_almost_empty(ae32)
    );

    fifo_fwft_sdp #(.DEPTH(20), .ADDR_WIDTH(5)) u20 (
        .clk(clk), .reset(reset), .if_write(w20), .if_din(d20), .if_full_n(fn20),
        .if_read(r20), .if_dout(dout20), .if_empty_n(en20), .if_num_data(num20),
        .if_almost_full(af20), .if_almost_empty(ae20)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        w;
        logic [63:0] d;
        logic        r;
        logic        en;
        logic [63:0] dout;
        int          num;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } ent_t;

    vec_t tv[9];
    ent_t q[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tv[0] = '{1'b1, 64'hA5, 1'b0, 1'b0, 64'h0, 0};
        tv[1] = '{1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1};
        tv[2] = '{1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1};
        tv[3] = '{1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1};
        tv[4] = '{1'b0, 64'h0, 1'b0, 1'b1, 64'hA5, 1};
        tv[5] = '{1'b0, 64'h0, 1'b1, 1'b1, 64'hA5, 1};
        tv[6] = '{1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 0};
        tv[7] = '{1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 0};
        tv[8] = '{1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_full_n", fn32, 0);
        chk("rst_empty_n", en32, 0);
        chk("rst_dout", dout32, 0);
        chk("rst_num", num32, 0);
        chk("rst_aempty", ae32, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_full_n", fn32, 1);
        chk("post_rst_empty_n", en32, 0);

        // single word latency, pop, and read while empty
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            w32 = tv[i].w; d32 = tv[i].d; r32 = tv[i].r;
            @(negedge clk);
            chk("tv_empty_n", en32, tv[i].en);
            chk("tv_num", num32, 64'(tv[i].num));
            if (tv[i].en) chk("tv_dout", dout32, tv[i].dout);
        end

        // fill to capacity, then one ignored write
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            w32 = 1'b1; d32 = 64'(i); r32 = 1'b0;
            @(negedge clk);
            chk("fill_num", num32, 64'(i));
            chk("fill_full_n", fn32, 1);
            chk("fill_afull", af32, 64'(i >= 30));
        end
        @(posedge clk); #1;
        d32 = 64'h99;
        @(negedge clk);
        chk("full_full_n", fn32, 0);
        chk("full_num", num32, 32);
        chk("full_afull", af32, 1);

        // back-to-back drain
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            w32 = 1'b0; r32 = 1'b1;
            @(negedge clk);
            chk("drain_empty_n", en32, 1);
            chk("drain_dout", dout32, 64'(i));
            chk("drain_num", num32, 64'(32 - i));
            chk("drain_full_n", fn32, 64'(i != 0));
            chk("drain_aempty", ae32, 64'(32 - i <= 2));
        end
        @(posedge clk); #1;
        r32 = 1'b0;
        @(negedge clk);
        chk("drained_empty_n", en32, 0);
        chk("drained_num", num32, 0);
        @(posedge clk); #1;
        r32 = 1'b1;
        @(posedge clk); #1;
        r32 = 1'b0;
        @(negedge clk);
        chk("empty_read_num", num32, 0);
        chk("empty_read_empty_n", en32, 0);
        chk("empty_read_full_n", fn32, 1);

        // streaming: write and read every cycle
        for (int c = 0; c <= 204; c++) begin
            @(posedge clk); #1;
            w32 = c < 200; d32 = 64'(1000 + c); r32 = 1'b1;
            @(negedge clk);
            if (c < 4 || c == 204) chk("stream_empty", en32, 0);
            else begin
                chk("stream_empty_n", en32, 1);
                chk("stream_dout", dout32, 64'(1000 + c - 4));
            end
            if (c >= 4 && c < 200) chk("stream_num", num32, 4);
        end

        // reset with stored words and reads in flight
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            w32 = 1'b1; d32 = 64'(256 + i); r32 = i >= 10;
            @(negedge clk);
            if (i >= 10) chk("prerst_dout", dout32, 64'(256 + i - 10));
        end
        @(posedge clk); #1;
        w32 = 1'b0; r32 = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("midrst_empty_n", en32, 0);
        chk("midrst_full_n", fn32, 0);
        chk("midrst_num", num32, 0);
        chk("midrst_dout", dout32, 0);
        chk("midrst_aempty", ae32, 1);
        @(posedge clk); #1;
        reset = 1'b0; w32 = 1'b1; d32 = 64'h77;
        @(negedge clk);
        chk("rst2_full_n", fn32, 1);
        chk("rst2_num", num32, 0);
        chk("rst2_empty_n", en32, 0);
        for (int k = 1; k < 10; k++) begin
            @(posedge clk); #1;
            w32 = 1'b0; r32 = k == 4;
            @(negedge clk);
            chk("rst2_seq_empty_n", en32, 64'(k == 4));
            chk("rst2_seq_num", num32, 64'(k <= 4));
            if (k == 4) chk("rst2_dout", dout32, 64'h77);
        end
        r32 = 1'b0;

        // randomized traffic against a queue model, DEPTH=20
        for (int c = 0; c < 1000; c++) begin
            int ph, wp, rp;
            logic wa;
            ph = (c / 125) % 4;
            wp = ph == 0 ? 90 : ph == 1 ? 20 : ph == 2 ? 55 : 100;
            rp = ph == 0 ? 25 : ph == 1 ? 90 : ph == 2 ? 50 : 100;
            @(posedge clk); #1;
            w20 = $urandom_range(99) < wp;
            r20 = $urandom_range(99) < rp;
            d20 = {$urandom, $urandom};
            @(negedge clk);
            chk("rnd_num", num20, 64'(q.size()));
            chk("rnd_full_n", fn20, 64'(q.size() != 20));
            chk("rnd_afull", af20, 64'(q.size() >= 18));
            chk("rnd_aempty", ae20, 64'(q.size() <= 2));
            chk("rnd_bound", 64'(num20 > 20), 0);
            if (en20) begin
                if (q.size() == 0) chk("rnd_spurious_head", en20, 0);
                else chk("rnd_dout", dout20, q[0].data);
            end else if (q.size() > 0) begin
                chk("rnd_head_late", 64'(c - q[0].cyc >= 4), 0);
            end
            wa = w20 && q.size() < 20;
            if (r20 && en20 && q.size() > 0) void'(q.pop_front());
            if (wa) q.push_back('{d20, c});
        end
        w20 = 1'b0; r20 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_fwft_sdp.md
Name: fifo_fwft_sdp

Overview:
- Parametrised first-word-fall-through FIFO for inter-kernel streams.
- Built on a simple-dual-port RAM with a registered read address and a registered output (2-cycle read), plus a small register prefetch stage.
- Adds occupancy count and almost-full/almost-empty flags, and sustains 1 word/cycle in and out.
- Uses the HLS-style handshake (full_n/write, empty_n/read) so it drops into generated kernel top-levels.

Parameters:
- MEM_STYLE, "auto", ram_style attribute passed to the RAM.
- DATA_WIDTH, 64, word width in bits (1..1024).
- DEPTH, 32, total capacity in words (≥ 4; need not be a power of two).
- ADDR_WIDTH, 6, RAM address width; must satisfy 2**ADDR_WIDTH ≥ DEPTH.
- AFULL_LEVEL, DEPTH-2, if_almost_full asserted when count ≥ AFULL_LEVEL.
- AEMPTY_LEVEL, 2, if_almost_empty asserted when count ≤ AEMPTY_LEVEL.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- if_write  in  1  write request; accepted when if_write && if_full_n.
- if_din  in  DATA_WIDTH  write data.
- if_full_n  out  1  1 = space available.
- if_read  in  1  read request; accepted when if_read && if_empty_n.
- if_dout  out  DATA_WIDTH  head word, valid whenever if_empty_n = 1.
- if_empty_n  out  1  1 = head word valid.
- if_num_data  out  ADDR_WIDTH+1  count = accepted writes − accepted reads.
- if_almost_full  out  1  count ≥ AFULL_LEVEL.
- if_almost_empty  out  1  count ≤ AEMPTY_LEVEL.

Behaviour:
- Reset: while reset is high, if_full_n=0, if_empty_n=0, if_dout=0, count=0, pointers=0, staging cleared, in-flight reads discarded. if_almost_empty=1. if_full_n=1 in the first cycle after reset falls.
- Reset mid-operation: all stored data is lost; no word issued before reset ever appears after it.
- Write: an accepted write stores if_din at wptr; wptr wraps DEPTH-1 → 0.
- Read issue: a RAM read is issued in cycle c when RAM occupancy > 0 and (staging entries + in-flight reads) < 4 (localparam STAGE_DEPTH=4). raddr=rptr in cycle c, rden in c+1, data lands in staging at the end of c+2.
- rptr wrap: rptr wraps DEPTH-1 → 0.
- Head word: if_dout/if_empty_n come from the head of a 4-entry register FIFO (staging). An accepted if_read pops it; the next entry is visible the following cycle.
- Latency: a write accepted in cycle 0 into an empty FIFO gives if_empty_n=1 with that word in cycle 4.
- Throughput: with if_read held high, 1 word/cycle is sustained once primed (no bubbles).
- Count update: count +1 on accepted write, −1 on accepted read. A simultaneous write and read leaves it unchanged.
- Status flags: if_full_n = (count != DEPTH) and is decoded from the count register, so a read in cycle t frees space from t+1. if_num_data, if_almost_full and if_almost_empty are also decoded from the count register.
- Write when full: if_write with if_full_n=0 is ignored and does not change state.
- Read when empty: if_read with if_empty_n=0 is ignored.
- RAM collision: the RAM may read and write the same address in one cycle only when RAM occupancy is 0, which the issue rule forbids. No read-during-write value is ever consumed.
- Ordering: strict FIFO order; no duplication or loss of words.

Decomposition:
- No shared package required.
- Localparams inside the module: STAGE_DEPTH=4, CNT_W=ADDR_WIDTH+1.
- One sub-module: fifo_sdp_ram2. Write port; registered raddr; dout register with reset and rden; ram_style=MEM_STYLE.
- Pointer, credit and count logic live in the top-level module.

Test Plan:
- Single word, DEPTH=32: write 0xA5 in cycle 0 with if_read=0 -> if_empty_n=1, if_dout=0xA5 in cycle 4; if_num_data=1 from cycle 1.
- Fill: write 32 words (0..31) with no reads -> if_full_n=0 after the 32nd; 33rd write ignored; if_almost_full=1 from count 30.
- Drain: read all 32 words -> values 0..31 in order, if_empty_n=0 after the last; a read while empty changes nothing.
- Streaming: write and read every cycle for 200 words -> 1 word/cycle out after priming, if_num_data constant, no gaps.
- Wrap and backpressure: DEPTH=20, random if_write/if_read for 1000 cycles -> scoreboard matches exactly and count never exceeds 20.
- Reset: reset pulsed with 10 words stored and reads in flight -> if_empty_n=0, count=0. Next written word 0x77 appears first, in cycle 4 after its write.
